// File: rtl/param_updown_counter.sv
// -----------------------------------------------------------------------------
// param_updown_counter
//
// Modulo-(MAX_VALUE+1) up/down counter with count enable, wrap or saturate
// behaviour at the limits, a combinational limit flag and a one-cycle wrap
// pulse. Serves as the generic timebase/event counter of the sequential-block
// library.
//
// Optional feature macro: UPDOWN_COUNTER_LOAD_EN
//   defined   -> synchronous parallel load (loadEn/loadValue) is built; the
//                load has priority over counting and is clamped to MAX_VALUE.
//   undefined -> no load logic; loadEn/loadValue stay as ports but are ignored.
//
// Parameters:
//   WIDTH       bit width of the count register (2..32)
//   MAX_VALUE   highest count value, 1..2**WIDTH-1 (modulus is MAX_VALUE+1)
//   SATURATE    0 = wrap at the limits, 1 = hold at the limits
//   RESET_VALUE count loaded on reset, <= MAX_VALUE
//
// Ports:
//   clockPulse  in   1      sole clock, rising edge
//   resetPulse  in   1      asynchronous, active-high reset
//   enable      in   1      count enable
//   upDown      in   1      direction: 1 = up, 0 = down
//   loadEn      in   1      synchronous load request (macro builds only)
//   loadValue   in   WIDTH  value to load
//   Result      out  WIDTH  current count (registered)
//   atLimit     out  1      count sits at the limit in the current direction
//                           (combinational)
//   wrapPulse   out  1      high for one cycle after a wrapping edge
//                           (registered)
// -----------------------------------------------------------------------------
module param_updown_counter #(
    parameter int          WIDTH       = 4,
    parameter int unsigned MAX_VALUE   = (2 ** WIDTH) - 1,
    parameter bit          SATURATE    = 1'b0,
    parameter int unsigned RESET_VALUE = 0
) (
    input  logic             clockPulse,
    input  logic             resetPulse,
    input  logic             enable,
    input  logic             upDown,
    input  logic             loadEn,
    input  logic [WIDTH-1:0] loadValue,
    output logic [WIDTH-1:0] Result,
    output logic             atLimit,
    output logic             wrapPulse
);

    // Limits expressed at the register width. With WIDTH = 32 the default
    // MAX_VALUE evaluates to all ones through 32-bit wrap of 2**32 - 1.
    localparam logic [WIDTH-1:0] MAX_W   = MAX_VALUE[WIDTH-1:0];
    localparam logic [WIDTH-1:0] RESET_W = RESET_VALUE[WIDTH-1:0];

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q,  wrap_d;
    logic             load_req;
    logic [WIDTH-1:0] load_val;
    logic             at_max, at_zero;

`ifdef UPDOWN_COUNTER_LOAD_EN
    assign load_req = loadEn;
    // Out-of-range loads are clamped so the count never leaves 0..MAX_VALUE.
    assign load_val = (loadValue > MAX_W) ? MAX_W : loadValue;
`else
    // Load path not built: the ports are kept so both builds share one port
    // list, and are folded into a sink that drives nothing.
    logic unused_load;
    assign unused_load = loadEn ^ (^loadValue);
    assign load_req    = 1'b0;
    assign load_val    = '0;
`endif

    assign at_max  = (count_q == MAX_W);
    assign at_zero = (count_q == '0);

    // Next-state: load > count > hold. wrap_d is high only on a wrapping step.
    always_comb begin
        // NOTE: every output of this block gets a default before any branch;
        // a path that leaves one unassigned would infer a latch.
        count_d = count_q;
        wrap_d  = 1'b0;

        if (load_req) begin
            count_d = load_val;
        end else if (enable) begin
            if (upDown) begin
                if (!at_max) begin
                    count_d = count_q + WIDTH'(1);
                end else if (!SATURATE) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end
            end else begin
                if (!at_zero) begin
                    count_d = count_q - WIDTH'(1);
                end else if (!SATURATE) begin
                    count_d = MAX_W;
                    wrap_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clockPulse or posedge resetPulse) begin
        if (resetPulse) begin
            count_q <= RESET_W;
            wrap_q  <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every
            // flop samples the pre-edge values computed by the comb block.
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign Result    = count_q;
    assign wrapPulse = wrap_q;
    // Direction is taken live, so the flag tracks upDown within the cycle.
    assign atLimit   = upDown ? at_max : at_zero;

endmodule

// File: tb/tb_param_updown_counter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_param_updown_counter
//
// Drives a wrapping (SATURATE=0) and a saturating (SATURATE=1) instance of
// param_updown_counter, both WIDTH=4 / MAX_VALUE=9, from shared inputs. A
// behavioural model written with modular arithmetic tracks both counts and
// wrap flags; directed scenarios additionally compare against literal
// sequences. Inputs change on the falling edge, outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_param_updown_counter;

  localparam int          W    = 4;
  localparam int unsigned MAXV = 9;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         ud;
  logic         ld;
  logic [W-1:0] lv;

  logic [W-1:0] res0, res1;
  logic         lim0, lim1, wp0, wp1;

  int checks = 0;
  int errors = 0;

  // Model state: index 0 = wrapping instance, 1 = saturating instance.
  int unsigned mv [2];
  bit          mw [2];

  always #50 clk = ~clk;

  param_updown_counter #(.WIDTH(W), .MAX_VALUE(MAXV), .SATURATE(1'b0), .RESET_VALUE(0)) dut_wrap (
    .clockPulse(clk), .resetPulse(rst), .enable(en), .upDown(ud),
    .loadEn(ld), .loadValue(lv), .Result(res0), .atLimit(lim0), .wrapPulse(wp0)
  );

  param_updown_counter #(.WIDTH(W), .MAX_VALUE(MAXV), .SATURATE(1'b1), .RESET_VALUE(0)) dut_sat (
    .clockPulse(clk), .resetPulse(rst), .enable(en), .upDown(ud),
    .loadEn(ld), .loadValue(lv), .Result(res1), .atLimit(lim1), .wrapPulse(wp1)
  );

  task automatic check(input bit ok, input string msg);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s", msg);
    end
  endtask

  function automatic bit load_active(input bit l);
`ifdef UPDOWN_COUNTER_LOAD_EN
    return l;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int unsigned ref_next(input int unsigned cur, input bit sat,
                                           input bit e, input bit u, input bit l,
                                           input int unsigned lval);
    if (load_active(l)) return (lval > MAXV) ? MAXV : lval;
    if (!e) return cur;
    if (sat) begin
      if (u) return (cur == MAXV) ? MAXV : cur + 1;
      return (cur == 0) ? 0 : cur - 1;
    end
    return u ? (cur + 1) % (MAXV + 1) : (cur + MAXV) % (MAXV + 1);
  endfunction

  function automatic bit ref_wrap(input int unsigned cur, input bit sat,
                                  input bit e, input bit u, input bit l);
    if (load_active(l) || !e || sat) return 1'b0;
    return u ? (cur == MAXV) : (cur == 0);
  endfunction

  // Expected {Result, wrapPulse, atLimit} for both instances, given live upDown.
  function automatic logic [11:0] exp_vec();
    logic [W-1:0] v0, v1;
    bit l0, l1;
    v0 = W'(mv[0]);
    v1 = W'(mv[1]);
    l0 = ud ? (mv[0] == MAXV) : (mv[0] == 0);
    l1 = ud ? (mv[1] == MAXV) : (mv[1] == 0);
    return {v0, mw[0], l0, v1, mw[1], l1};
  endfunction

  logic [11:0] obs;
  assign obs = {res0, wp0, lim0, res1, wp1, lim1};

  // One clock: model updates on the rising edge from the inputs in force,
  // then returns at the falling edge where outputs are compared.
  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      mw[i] = ref_wrap(mv[i], (i == 1), en, ud, ld);
      mv[i] = ref_next(mv[i], (i == 1), en, ud, ld, lv);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    ud  = 1'b1;
    ld  = 1'b0;
    lv  = '0;
    mv[0] = 0; mv[1] = 0;
    mw[0] = 1'b0; mw[1] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; ud = 1'b1; ld = 1'b0; lv = '0;
    mv[0] = 0; mv[1] = 0; mw[0] = 1'b0; mw[1] = 1'b0;
    #1;
    check({res0, wp0} === {4'd0, 1'b0},
          $sformatf("reset_initial: got Result=%0d wrap=%b, want 0/0", res0, wp0));
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;
    repeat (6) tick();
    check(res0 === 4'd6, $sformatf("reset_precount: got Result=%0d, want 6", res0));
    // Assert reset between edges with enable still high.
    #10 rst = 1'b1;
    mv[0] = 0; mv[1] = 0; mw[0] = 1'b0; mw[1] = 1'b0;
    #1;
    check({res0, wp0} === {4'd0, 1'b0},
          $sformatf("reset_async: got Result=%0d wrap=%b, want 0/0", res0, wp0));
    repeat (2) @(posedge clk);
    #1;
    check({res0, wp0, res1, wp1} === 10'd0,
          $sformatf("reset_hold: got Result=%0d/%0d wrap=%b/%b, want 0", res0, res1, wp0, wp1));
    @(negedge clk);
    rst = 1'b0;
    tick();
    check(res0 === 4'd1, $sformatf("reset_release: got Result=%0d, want 1", res0));
    check(obs === exp_vec(),
          $sformatf("reset_release_model: got %h, want %h", obs, exp_vec()));
  endtask

  task automatic test_up_wrap();
    logic [W-1:0] k;
    do_reset();
    en = 1'b1; ud = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      k = W'((i + 1) % 10);
      check({res0, wp0, lim0} === {k, (k == 0), (k == 9)},
            $sformatf("up_wrap step %0d: got R=%0d w=%b lim=%b, want R=%0d w=%b lim=%b",
                      i, res0, wp0, lim0, k, (k == 0), (k == 9)));
      check(obs === exp_vec(),
            $sformatf("up_wrap_model step %0d: got %h, want %h", i, obs, exp_vec()));
    end
  endtask

  task automatic test_down_dirchange();
    logic [W-1:0] seq [3];
    seq[0] = 4'd1; seq[1] = 4'd0; seq[2] = 4'd9;
    do_reset();
    en = 1'b1; ud = 1'b1;
    repeat (2) tick();
    ud = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check({res0, wp0} === {seq[i], (i == 2)},
            $sformatf("down_wrap step %0d: got R=%0d w=%b, want R=%0d w=%b",
                      i, res0, wp0, seq[i], (i == 2)));
    end
    // At 9 counting down the flag is low; flipping direction raises it at once.
    check(lim0 === 1'b0, $sformatf("atlimit_down_at9: got %b, want 0", lim0));
    ud = 1'b1;
    #1;
    check(lim0 === 1'b1, $sformatf("atlimit_up_at9: got %b, want 1", lim0));
    tick();
    check({res0, wp0} === {4'd0, 1'b1},
          $sformatf("dir_change_wrap: got R=%0d w=%b, want R=0 w=1", res0, wp0));
    check(obs === exp_vec(),
          $sformatf("dir_change_model: got %h, want %h", obs, exp_vec()));
  endtask

  task automatic test_saturate();
    do_reset();
    en = 1'b1; ud = 1'b1;
    repeat (8) tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      check({res1, wp1, lim1} === {4'd9, 1'b0, 1'b1},
            $sformatf("sat_up step %0d: got R=%0d w=%b lim=%b, want R=9 w=0 lim=1",
                      i, res1, wp1, lim1));
    end
    do_reset();
    en = 1'b1; ud = 1'b1;
    tick();
    ud = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check({res1, wp1} === {4'd0, 1'b0},
            $sformatf("sat_down step %0d: got R=%0d w=%b, want R=0 w=0", i, res1, wp1));
      check(obs === exp_vec(),
            $sformatf("sat_model step %0d: got %h, want %h", i, obs, exp_vec()));
    end
  endtask

  task automatic test_load();
    logic [W-1:0] want_a, want_b;
`ifdef UPDOWN_COUNTER_LOAD_EN
    want_a = 4'd5; want_b = 4'd9;
`else
    want_a = 4'd4; want_b = 4'd5;
`endif
    do_reset();
    en = 1'b1; ud = 1'b1;
    repeat (3) tick();
    ld = 1'b1; lv = 4'd5;
    tick();
    check(res0 === want_a, $sformatf("load_basic: got R=%0d, want %0d", res0, want_a));
    lv = 4'd14;
    tick();
    check(res0 === want_b, $sformatf("load_clamp: got R=%0d, want %0d", res0, want_b));
    // A load at the limit must suppress the wrap that counting would give.
    ld = 1'b0;
    while (mv[0] != MAXV) tick();
    ld = 1'b1; lv = 4'd3;
    tick();
    check(obs === exp_vec(),
          $sformatf("load_at_limit: got %h, want %h", obs, exp_vec()));
    ld = 1'b0;
  endtask

  task automatic test_hold();
    do_reset();
    en = 1'b1; ud = 1'b1;
    repeat (4) tick();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check({res0, wp0} === {4'd4, 1'b0},
            $sformatf("hold step %0d: got R=%0d w=%b, want R=4 w=0", i, res0, wp0));
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(3) != 0);
      ud = $urandom_range(1);
      ld = ($urandom_range(7) == 0);
      lv = W'($urandom_range(15));
      tick();
      check(obs === exp_vec(),
            $sformatf("random cycle %0d: got %h, want %h", i, obs, exp_vec()));
    end
    ld = 1'b0;
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_dirchange();
    test_saturate();
    test_load();
    test_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
